// File: rtl/drive_mode_arbiter_pkg.sv
// Shared encodings for the drive-mode controller and the driver modules.
// sanitize_cmd() is the single place that decides which motor commands are legal.
package drive_mode_arbiter_pkg;

    localparam logic [3:0] MS_STOP     = 4'b0000;
    localparam logic [3:0] MS_FORWARD  = 4'b0001;
    localparam logic [3:0] MS_BACKWARD = 4'b0010;
    localparam logic [3:0] MS_LEFT     = 4'b0100;
    localparam logic [3:0] MS_RIGHT    = 4'b1000;

    typedef enum logic [1:0] {
        GS_NONE   = 2'b00,
        GS_SEMI   = 2'b01,
        GS_AUTO   = 2'b10,
        GS_MANUAL = 2'b11
    } gmode_e;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ARM   = 2'b01,
        ST_ON    = 2'b10,
        ST_DRAIN = 2'b11
    } ctrl_state_e;

    // Multi-bit commands, and reversing outside MANUAL, collapse to STOP.
    function automatic logic [3:0] sanitize_cmd(input logic [3:0] cmd, input gmode_e mode);
        if ((cmd & (cmd - 4'd1)) != 4'd0) return MS_STOP;
        if (cmd[1] && (mode != GS_MANUAL)) return MS_STOP;
        return cmd;
    endfunction

endpackage

// File: rtl/drive_mode_arbiter_if.sv
// Front-panel, driver-command and motor/light signals of the drive-mode arbiter.
// The slave side is the arbiter; the master side is whoever drives panel and drivers.
interface drive_mode_arbiter_if;
    logic       power_btn;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic [3:0] manual_cmd;
    logic [3:0] semi_cmd;
    logic [3:0] auto_cmd;
    logic       power;
    logic [1:0] global_state;
    logic [3:0] moving_state;
    logic       move_forward_light;
    logic       move_backward_light;
    logic       turn_left_light;
    logic       turn_right_light;
    logic       mode_busy;

    modport master (
        output power_btn, mode_req, mode_sel, manual_cmd, semi_cmd, auto_cmd,
        input  power, global_state, moving_state, move_forward_light,
               move_backward_light, turn_left_light, turn_right_light, mode_busy
    );

    modport slave (
        input  power_btn, mode_req, mode_sel, manual_cmd, semi_cmd, auto_cmd,
        output power, global_state, moving_state, move_forward_light,
               move_backward_light, turn_left_light, turn_right_light, mode_busy
    );
endinterface

// File: rtl/drive_mode_arbiter_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter advanced on the ms tick.
// The output level follows the raw input only after DEB_MS consecutive stable ticks.
module btn_debounce #(
    parameter int DEB_MS = 20
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o
);
    localparam int CW = $clog2(DEB_MS + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        // Any cycle where the input agrees with the output restarts the window.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CW'(DEB_MS - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/drive_mode_arbiter.sv
// Power-on sequencing, mode register and motor-command arbitration for the car.
// state    | meaning
// ST_OFF   | unpowered, outputs idle, waiting for power_btn
// ST_ARM   | power_btn held, counting ms ticks toward power-on
// ST_ON    | powered, active driver's command reaches the motors
// ST_DRAIN | mode switch pending, motors forced to STOP
module drive_mode_arbiter
    import drive_mode_arbiter_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int POWER_HOLD_MS = 1000,
    parameter int DEB_MS        = 20,
    parameter int DRAIN_MS      = 200
) (
    input logic             sys_clk,
    input logic             rst,
    drive_mode_arbiter_if.slave bus_if
);
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TW       = $clog2(TICK_DIV + 1);
    localparam int HW       = $clog2(POWER_HOLD_MS + 1);
    localparam int DW       = $clog2(DRAIN_MS + 1);

    logic [TW-1:0] tick_cnt_q;
    logic          tick;

    logic          pwr_lvl, mode_lvl;
    logic          pwr_prev_q, mode_prev_q;
    logic          pwr_rise, mode_rise;

    ctrl_state_e   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [DW-1:0] drain_q, drain_d;
    gmode_e        pending_q, pending_d;
    gmode_e        gs_q, gs_d;
    logic          power_q, busy_q;
    logic [3:0]    moving_q, moving_d, sel_cmd;

    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end

    btn_debounce #(.DEB_MS(DEB_MS)) u_pwr_deb (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick_i  (tick),
        .raw_i   (bus_if.power_btn),
        .level_o (pwr_lvl)
    );

    btn_debounce #(.DEB_MS(DEB_MS)) u_mode_deb (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick_i  (tick),
        .raw_i   (bus_if.mode_req),
        .level_o (mode_lvl)
    );

    assign pwr_rise  = pwr_lvl & ~pwr_prev_q;
    assign mode_rise = mode_lvl & ~mode_prev_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        drain_d   = drain_q;
        pending_d = pending_q;
        gs_d      = gs_q;
        case (state_q)
            ST_OFF: begin
                gs_d = GS_NONE;
                if (pwr_lvl) begin
                    state_d = ST_ARM;
                    hold_d  = '0;
                end
            end
            ST_ARM: begin
                // Reaching the hold count wins over a release seen on the same tick.
                if (tick && (hold_q == HW'(POWER_HOLD_MS - 1))) begin
                    state_d = ST_ON;
                    gs_d    = GS_NONE;
                end else if (!pwr_lvl) begin
                    state_d = ST_OFF;
                end else if (tick) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_ON: begin
                if (pwr_rise) begin
                    state_d = ST_OFF;
                    gs_d    = GS_NONE;
                end else if (mode_rise && (bus_if.mode_sel != 2'b00) &&
                             (bus_if.mode_sel != gs_q)) begin
                    state_d   = ST_DRAIN;
                    pending_d = gmode_e'(bus_if.mode_sel);
                    drain_d   = DW'(DRAIN_MS - 1);
                end
            end
            ST_DRAIN: begin
                if (pwr_rise) begin
                    state_d   = ST_OFF;
                    gs_d      = GS_NONE;
                    pending_d = GS_NONE;
                end else if (tick) begin
                    if (drain_q == '0) begin
                        state_d = ST_ON;
                        gs_d    = pending_q;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        sel_cmd = MS_STOP;
        case (gs_q)
            GS_SEMI:   sel_cmd = bus_if.semi_cmd;
            GS_AUTO:   sel_cmd = bus_if.auto_cmd;
            GS_MANUAL: sel_cmd = bus_if.manual_cmd;
            default:   sel_cmd = MS_STOP;
        endcase
        moving_d = (state_q == ST_ON) ? sanitize_cmd(sel_cmd, gs_q) : MS_STOP;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            hold_q      <= '0;
            drain_q     <= '0;
            pending_q   <= GS_NONE;
            gs_q        <= GS_NONE;
            power_q     <= 1'b0;
            busy_q      <= 1'b0;
            moving_q    <= MS_STOP;
            pwr_prev_q  <= 1'b0;
            mode_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            drain_q     <= drain_d;
            pending_q   <= pending_d;
            gs_q        <= gs_d;
            power_q     <= (state_d == ST_ON) || (state_d == ST_DRAIN);
            busy_q      <= (state_d == ST_DRAIN);
            moving_q    <= moving_d;
            pwr_prev_q  <= pwr_lvl;
            mode_prev_q <= mode_lvl;
        end
    end

    assign bus_if.power               = power_q;
    assign bus_if.global_state        = gs_q;
    assign bus_if.moving_state        = moving_q;
    assign bus_if.mode_busy           = busy_q;
    assign bus_if.move_forward_light  = moving_q[0];
    assign bus_if.move_backward_light = moving_q[1];
    assign bus_if.turn_left_light     = moving_q[2];
    assign bus_if.turn_right_light    = moving_q[3];
endmodule

// File: doc/drive_mode_arbiter.md
# drive_mode_arbiter

Top-level power and mode controller for the car. It owns the power-on sequence and the `global_state` mode register, and shares the single motor-command path between the manual, semi-auto and auto drivers. Mode changes are sequenced through a forced-STOP drain window, so the chassis never switches from one driver's command to another's while moving. It sits between the debounced front-panel buttons and switches on one side, and the three driver modules plus the motor/light outputs on the other.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: `sys_clk` frequency; the 1 ms tick period is `CLK_HZ/1000` cycles.
- `POWER_HOLD_MS`, default 1000: continuous `power_btn` hold needed to power on.
- `DEB_MS`, default 20: button debounce stability window.
- `DRAIN_MS`, default 200: forced-STOP window before a mode switch takes effect.

Ports (clock and reset first):
- `sys_clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `power_btn` in 1: raw power button.
- `mode_req` in 1: raw mode-commit button.
- `mode_sel` in 2: mode switches; 01 SEMI, 10 AUTO, 11 MANUAL, 00 ignored.
- `manual_cmd` in 4: moving-state request from the manual driver.
- `semi_cmd` in 4: moving-state request from the semi-auto driver.
- `auto_cmd` in 4: moving-state request from the auto driver.
- `power` out 1: powered flag.
- `global_state` out 2: active mode; 00 NONE, 01 SEMI, 10 AUTO, 11 MANUAL.
- `moving_state` out 4: arbitrated motor command.
- `move_forward_light`, `move_backward_light`, `turn_left_light`, `turn_right_light` out 1 each: lights driven from `moving_state`.
- `mode_busy` out 1: high while a mode switch is pending or draining.

## Operation
- Moving-state encoding: STOP 0000, MOVE_FORWARD 0001, MOVE_BACKWARD 0010, TURN_LEFT 0100, TURN_RIGHT 1000.
- Inputs `power_btn` and `mode_req` pass through a 2-flop synchroniser and a debouncer. The debounced level changes only after the raw level has been stable for `DEB_MS` consecutive ticks.
- Controller FSM states are OFF, ARM, ON and DRAIN.
  - OFF: `power`=0, `global_state`=00, `moving_state`=STOP. Debounced `power_btn` high → ARM, hold counter cleared.
  - ARM: hold counter increments on each ms tick. Button released before the count reaches `POWER_HOLD_MS` → OFF. Count reaches `POWER_HOLD_MS` → ON with `global_state`=00.
  - ON: `power`=1. A debounced `power_btn` rising edge → OFF. A debounced `mode_req` rising edge with `mode_sel`≠00 and ≠`global_state` latches `mode_sel` into `pending_mode` → DRAIN. A rising edge with `mode_sel`=00 or equal to the current mode is ignored.
  - DRAIN: `moving_state` is forced to STOP and `mode_busy`=1. After `DRAIN_MS` ticks, `global_state`←`pending_mode` → ON. A `power_btn` rising edge during DRAIN → OFF and the pending mode is discarded. Further `mode_req` edges during DRAIN are ignored.
- Arbitration in ON selects the command by `global_state`: 01 `semi_cmd`, 10 `auto_cmd`, 11 `manual_cmd`, 00 STOP. Any other state outputs STOP.
- Illegal command values are replaced by STOP:
  - more than one bit set;
  - bit1 set while `global_state`≠11, because only the manual driver may reverse.
- Lights: forward = `moving_state[0]`, backward = `[1]`, left = `[2]`, right = `[3]`.

## Timing
- Reset values: FSM OFF, `power` 0, `global_state` 00, `moving_state` 0000, all lights 0, `mode_busy` 0, all counters 0.
- The ms tick is a one-cycle pulse. It is generated by a free-running counter that wraps at `CLK_HZ/1000-1`.
- `moving_state` and the lights are registered: one `sys_clk` cycle from a change on a `*_cmd` input to the outputs.
- Debounce latency is 2 cycles of synchronisation plus `DEB_MS` ticks, ±1 tick.
- Power-on: `power` rises exactly `POWER_HOLD_MS` ticks after ARM entry, ±1 tick.
- DRAIN lasts exactly `DRAIN_MS` ticks. `global_state` changes on the same cycle that `mode_busy` falls.
- A release at the same tick the hold count reaches `POWER_HOLD_MS` powers on.
- `rst` asserted mid-ARM or mid-DRAIN returns the block immediately to the reset values.

## Structure
- A shared package holds the moving-state constants, the `global_state` encodings and the FSM state encodings. The driver modules use the same package.
- One sub-module, `btn_debounce` (synchroniser plus stability counter, clocked by the ms tick enable), is instantiated twice.

## Test plan
Parameters for all scenarios: `CLK_HZ`=10_000, `POWER_HOLD_MS`=5, `DEB_MS`=2, `DRAIN_MS`=3.
- Hold `power_btn` for 10 ms → `power`=1 about 7 ms after the press, `global_state`=00, `moving_state`=0000.
- Hold `power_btn` for 3 ms, then release → block stays in OFF, `power` remains 0.
- Powered on: `mode_sel`=01, pulse `mode_req` for 4 ms, `semi_cmd`=0001 → `mode_busy`=1 for 3 ms with `moving_state`=0000, then `global_state`=01 and `moving_state`=0001 one cycle later.
- In SEMI, `semi_cmd`=0010 → `moving_state`=0000. Switch to MANUAL, then `manual_cmd`=0010 → `moving_state`=0010 and `move_backward_light`=1.
- During DRAIN, press `power_btn` → `power`=0 and `global_state`=00, with no mode change.
- Assert `rst` asynchronously during ARM → all outputs return to 0 within the same cycle.
